// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared parameters, state encoding and helpers for the carry-save accumulator
package csa_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int GUARD_DEF = 8;
  localparam int CHUNK_DEF = 8;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic int nch(input int wi, input int chunk);
    return wi / chunk;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// rtl/csa_3to2.sv - bitwise 3:2 carry-save compressor, carry output already shifted left by one
module csa_3to2 #(
  parameter int W = 40
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] maj;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  // Bit W-1 of the majority falls off the top: all arithmetic is mod 2^W.
  assign carry_o = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - streaming signed accumulator with carry-save folding and chunked resolve
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic             busy
);

  localparam int WI  = WIDTH + GUARD;
  localparam int NCH = nch(WI, CHUNK);
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = GUARD + 1;
  localparam logic [CW-1:0] TERM_LIM = CW'(1) << GUARD;
  localparam logic [CW-1:0] TERM_SAT = TERM_LIM + CW'(1);
  localparam logic [KW-1:0] K_LAST   = KW'(NCH - 1);

  state_e          state_q, state_d;
  logic [WI-1:0]   s_q, s_d, c_q, c_d, r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic            cr_q, cr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            ovf_q, ovf_d;
  logic            ov_q, ov_d;

  logic [WI-1:0]   din_ext, csa_sum, csa_carry;
  logic [CHUNK:0]  csum;
  logic [GUARD:0]  top_bits;

  assign din_ext = {{GUARD{in_data[WIDTH-1]}}, in_data};

  csa_3to2 #(.W(WI)) u_csa (
    .a_i    (s_q),
    .b_i    (c_q),
    .c_i    (din_ext),
    .sum_o  (csa_sum),
    .carry_o(csa_carry)
  );

  always_comb begin
    csum = {1'b0, s_q[int'(k_q)*CHUNK +: CHUNK]}
         + {1'b0, c_q[int'(k_q)*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, cr_q};
  end

  // Everything above the signed result MSB must be a copy of it for the total to fit.
  assign top_bits = r_q[WI-1:WIDTH-1];

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    cr_d    = cr_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          s_d = csa_sum;
          c_d = csa_carry;
          if (cnt_q != TERM_SAT) cnt_d = cnt_q + CW'(1);
          if (in_last) begin
            state_d = ST_RESOLVE;
            k_d     = '0;
            cr_d    = 1'b0;
          end
        end
      end
      ST_RESOLVE: begin
        r_d[int'(k_q)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        cr_d = csum[CHUNK];
        if (k_q == K_LAST) state_d = ST_DONE;
        else               k_d = k_q + KW'(1);
      end
      ST_DONE: begin
        if (!ov_q) begin
          ov_d  = 1'b1;
          sum_d = r_q[WIDTH-1:0];
          ovf_d = !((&top_bits) || !(|top_bits)) || (cnt_q > TERM_LIM);
        end else if (out_ready) begin
          state_d = ST_ACC;
          s_d     = '0;
          c_d     = '0;
          r_d     = '0;
          cnt_d   = '0;
          k_d     = '0;
          cr_d    = 1'b0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          ov_d    = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      cr_q    <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      cr_q    <= cr_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready     = (state_q == ST_ACC);
  assign out_valid    = ov_q;
  assign out_sum      = sum_q;
  assign out_overflow = ovf_q;
  assign busy         = (state_q != ST_ACC) || (cnt_q != '0);

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb/tb_csa_stream_accumulator.sv - directed self-checking bench for csa_stream_accumulator
module tb_csa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  csa_stream_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_overflow(out_overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_sum"}, 64'(out_sum), 64'd0);
    chk({tag, "_overflow"}, 64'(out_overflow), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic get_result(input string tag, input logic [31:0] exp_sum, input logic exp_ovf);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
    chk({tag, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single beat: out_valid must rise exactly on the sixth edge after acceptance.
    send(32'd5, 1'b1);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("single_lat_e%0d", i), 64'(out_valid), (i == 6) ? 64'd1 : 64'd0);
    end
    get_result("single", 32'd5, 1'b0);

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("seq_ready_b%0d", i), 64'(in_ready), 64'd1);
      send(32'(i), (i == 9));
    end
    get_result("seq0to9", 32'd45, 1'b0);

    send(-32'sd10, 1'b0);
    send(-32'sd5, 1'b0);
    send(32'd7, 1'b1);
    get_result("neg", 32'hFFFF_FFF8, 1'b0);

    send(32'h7FFF_FFFF, 1'b0);
    send(32'd1, 1'b1);
    get_result("ovf_pos", 32'h8000_0000, 1'b1);

    send(32'h8000_0000, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    get_result("ovf_neg", 32'h7FFF_FFFF, 1'b1);

    send(32'hFFFF_FFFF, 1'b0);
    send(32'd1, 1'b1);
    get_result("wrap_zero", 32'd0, 1'b0);

    // Term limit boundary: 256 terms are exact, 257 force the flag.
    for (int i = 0; i < 256; i++) send(32'd1, (i == 255));
    get_result("terms256", 32'd256, 1'b0);
    for (int i = 0; i < 257; i++) send(32'd1, (i == 256));
    get_result("terms257", 32'd257, 1'b1);

    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_valid_c%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_sum_c%0d", i), 64'(out_sum), 64'd30);
      chk($sformatf("bp_in_ready_c%0d", i), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    get_result("bp_first", 32'd30, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    get_result("bp_next", 32'd5, 1'b0);

    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    send(32'd9, 1'b0);
    chk("mid_pkt_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_pkt");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    send(32'd123, 1'b1);
    tick();
    tick();
    chk("resolve_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_resolve");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    send(32'd1, 1'b0);
    send(32'd1, 1'b1);
    get_result("post_reset", 32'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
